// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, packer state encoding and block geometry helper for the AES word packer.
package aes_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [1:0] {
        FILL,
        FULL,
        WAIT_FB
    } pk_state_e;

    function automatic int nw_of(input int word_w);
        return AES_BLK_W / word_w;
    endfunction

endpackage

// File: rtl/aes_word_packer.sv
// aes_word_packer: packs WORD_W-bit plaintext words into 128-bit AES input blocks; optional CBC chaining under AES_CBC_CHAIN_EN.
module aes_word_packer
    import aes_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [WORD_W-1:0]                 s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [AES_BLK_W-1:0]              m_block,
    output logic [$clog2(nw_of(WORD_W)):0]    words_held
`ifdef AES_CBC_CHAIN_EN
    ,
    input  logic                              iv_load,
    input  logic [AES_BLK_W-1:0]              iv,
    input  logic                              fb_valid,
    input  logic [AES_BLK_W-1:0]              fb_data
`endif
);

    localparam int NW = nw_of(WORD_W);
    localparam int CW = $clog2(NW) + 1;

    pk_state_e            r_state, w_state_nxt;
    logic [CW-1:0]        r_cnt, w_cnt_nxt;
    logic [AES_BLK_W-1:0] r_acc, w_acc_nxt;
    logic [AES_BLK_W-1:0] r_block, w_block_nxt;
    logic [AES_BLK_W-1:0] w_acc_word;
    logic [AES_BLK_W-1:0] w_mask;
    logic                 r_s_ready;
    logic                 r_m_valid;
    logic                 w_take;
    logic                 w_last;

`ifdef AES_CBC_CHAIN_EN
    logic [AES_BLK_W-1:0] r_chain, w_chain_nxt;
    assign w_mask = r_chain;
`else
    assign w_mask = '0;
`endif

    // Earlier words shift toward the MSB so word 0 ends up most significant.
    assign w_acc_word = {r_acc[AES_BLK_W-WORD_W-1:0], s_data};
    assign w_take     = s_valid && r_s_ready;
    assign w_last     = r_cnt == CW'(NW - 1);

    assign s_ready    = r_s_ready;
    assign m_valid    = r_m_valid;
    assign m_block    = r_block;
    assign words_held = (r_state == FILL) ? r_cnt : CW'(NW);

    // Next-state logic: flush overrides everything except chain loading.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_block_nxt = r_block;
`ifdef AES_CBC_CHAIN_EN
        w_chain_nxt = r_chain;
`endif
        if (flush) begin
            w_state_nxt = FILL;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_take) begin
                        w_acc_nxt = w_acc_word;
                        w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) begin
                            w_state_nxt = FULL;
                            w_block_nxt = w_acc_word ^ w_mask;
                        end
                    end
                end
                FULL: begin
`ifdef AES_CBC_CHAIN_EN
                    if (m_ready) w_state_nxt = WAIT_FB;
`else
                    if (m_ready) w_state_nxt = FILL;
`endif
                end
                default: begin
`ifdef AES_CBC_CHAIN_EN
                    if (fb_valid) begin
                        w_state_nxt = FILL;
                        w_chain_nxt = fb_data;
                    end
`else
                    w_state_nxt = FILL;
`endif
                end
            endcase
        end
`ifdef AES_CBC_CHAIN_EN
        // A new IV always wins and abandons any feedback still pending.
        if (iv_load) begin
            w_chain_nxt = iv;
            if (r_state == WAIT_FB) w_state_nxt = FILL;
        end
`endif
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= FILL;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_block   <= '0;
            r_s_ready <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_acc     <= w_acc_nxt;
            r_block   <= w_block_nxt;
            r_s_ready <= w_state_nxt == FILL;
            r_m_valid <= w_state_nxt == FULL;
        end
    end

`ifdef AES_CBC_CHAIN_EN
    // Chain register survives flush; only reset, IV load and feedback change it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_chain <= '0;
        else r_chain <= w_chain_nxt;
    end
`endif

endmodule

// File: tb/tb_aes_word_packer.sv
// tb_aes_word_packer: scoreboard bench for aes_word_packer (WORD_W=32); chaining scenarios run when AES_CBC_CHAIN_EN is defined.
module tb_aes_word_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [127:0] m_block;
    logic [2:0]   words_held;
`ifdef AES_CBC_CHAIN_EN
    logic         iv_load = 1'b0;
    logic [127:0] iv = '0;
    logic         fb_valid = 1'b0;
    logic [127:0] fb_data = '0;
`endif

    int total = 0;
    int bad = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;

    aes_word_packer #(.WORD_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_block(m_block),
        .words_held(words_held)
`ifdef AES_CBC_CHAIN_EN
        ,
        .iv_load(iv_load),
        .iv(iv),
        .fb_valid(fb_valid),
        .fb_data(fb_data)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready && !flush) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_block got=%h required=none", m_block);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (m_block !== e) begin
                    bad++;
                    $display("FAIL block got=%h required=%h", m_block, e);
                end
            end
        end
    end

    task automatic send(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        s_valid = 1'b1;
        s_data = w;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL send_timeout word=%h got=s_ready_low required=accept", w);
        end
    endtask

    task automatic send_block(input logic [127:0] b);
        logic [127:0] t;
        t = b;
        for (int i = 0; i < 4; i++) send(t[127-32*i -: 32]);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout got=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({s_ready, m_valid, m_block, words_held} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b/%b/%h/%0d required=0/0/0/0", s_ready, m_valid, m_block, words_held);
        end
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (s_ready !== 1'b1 || words_held !== 3'd0) begin
            bad++;
            $display("FAIL reset_release got=s_ready %b held %0d required=1 0", s_ready, words_held);
        end
    endtask

    task automatic test_fips();
        m_ready = 1'b1;
        exp_q.push_back(FIPS_PT);
        send_block(FIPS_PT);
        total++;
        if (m_valid !== 1'b1 || m_block !== FIPS_PT || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL fips_latency got=v%b %h r%b required=v1 %h r0", m_valid, m_block, s_ready, FIPS_PT);
        end
        @(posedge clk);
        #1;
        total++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            bad++;
            $display("FAIL fips_single_cycle got=v%b r%b required=v0 r1", m_valid, s_ready);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [127:0] b2;
        b2 = 128'hdeadbeef0123456789abcdeffedcba98;
        m_ready = 1'b0;
        exp_q.push_back(FIPS_PT);
        send_block(FIPS_PT);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (m_valid !== 1'b1 || m_block !== FIPS_PT || s_ready !== 1'b0 || words_held !== 3'd4) begin
                bad++;
                $display("FAIL hold_cycle%0d got=v%b %h r%b h%0d required=v1 %h r0 h4", i, m_valid, m_block, s_ready, words_held, FIPS_PT);
            end
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drain();
        exp_q.push_back(b2);
        send_block(b2);
        drain();
    endtask

    task automatic test_flush();
        m_ready = 1'b1;
        send(32'h11111111);
        send(32'h22222222);
        total++;
        if (words_held !== 3'd2) begin
            bad++;
            $display("FAIL flush_pre_held got=%0d required=2", words_held);
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        total++;
        if (words_held !== 3'd0 || s_ready !== 1'b1 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_state got=h%0d r%b v%b required=h0 r1 v0", words_held, s_ready, m_valid);
        end
        exp_q.push_back({4{32'ha0a0a0a0}});
        send_block({4{32'ha0a0a0a0}});
        drain();
        repeat (3) @(posedge clk);
    endtask

    task automatic test_async_reset();
        logic [127:0] b;
        b = 128'h0f0e0d0c0b0a09080706050403020100;
        m_ready = 1'b1;
        send(32'h12345678);
        send(32'h9abcdef0);
        send(32'h0badc0de);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({s_ready, m_valid, m_block, words_held} !== '0) begin
            bad++;
            $display("FAIL async_reset got=%b/%b/%h/%0d required=0/0/0/0", s_ready, m_valid, m_block, words_held);
        end
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(b);
        send_block(b);
        drain();
        repeat (3) @(posedge clk);
    endtask

`ifdef AES_CBC_CHAIN_EN
    task automatic test_chain();
        logic [127:0] ct;
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        m_ready = 1'b1;
        iv = 128'h000102030405060708090a0b0c0d0e0f;
        iv_load = 1'b1;
        @(posedge clk);
        #1;
        iv_load = 1'b0;
        exp_q.push_back(128'h00102030405060708090a0b0c0d0e0f0);
        send_block(FIPS_PT);
        drain();
        repeat (3) begin
            @(negedge clk);
            total++;
            if (s_ready !== 1'b0 || words_held !== 3'd4) begin
                bad++;
                $display("FAIL wait_fb got=r%b h%0d required=r0 h4", s_ready, words_held);
            end
        end
        @(posedge clk);
        #1;
        fb_data = ct;
        fb_valid = 1'b1;
        @(posedge clk);
        #1;
        fb_valid = 1'b0;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("FAIL fb_release got=%b required=1", s_ready);
        end
        exp_q.push_back(ct);
        send_block('0);
        drain();
    endtask

    task automatic test_collision();
        logic [127:0] x;
        x = 128'hcafef00d0000111122223333deadbeef;
        iv = x;
        fb_data = 128'h55555555aaaaaaaa55555555aaaaaaaa;
        iv_load = 1'b1;
        fb_valid = 1'b1;
        @(posedge clk);
        #1;
        iv_load = 1'b0;
        fb_valid = 1'b0;
        exp_q.push_back(x);
        send_block('0);
        drain();
        iv_load = 1'b1;
        iv = '0;
        @(posedge clk);
        #1;
        iv_load = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_fips();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef AES_CBC_CHAIN_EN
        fb_valid = 1'b1;
        fb_data = '1;
        @(posedge clk);
        #1;
        fb_valid = 1'b0;
        test_chain();
        test_collision();
`endif
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL final_idle got=q%0d v%b required=q0 v0", exp_q.size(), m_valid);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
